// File: rtl/rca_seq_pkg.sv
// Shared types and helpers for the sequential ripple-carry adder.
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational SLICE-bit ripple chain of full adders.
module rca_slice #(
    parameter int unsigned SLICE = 3
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic c;

    always_comb begin
        c   = cin;
        sum = '0;
        for (int i = 0; i < int'(SLICE); i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/rca_seq_adder.sv
// Multi-cycle WIDTH-bit adder reusing one SLICE-bit ripple slice, LSB slice first,
// with a start/busy/done handshake.
module rca_seq_adder
    import rca_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned SLICE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NSLICE = (SLICE == 0) ? 1 : WIDTH / SLICE;
    localparam int unsigned IDXW   = clog2_min1(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    if ((SLICE < 1) || ((WIDTH % ((SLICE == 0) ? 1 : SLICE)) != 0)) begin : g_bad_params
        $error("rca_seq_adder: WIDTH must be a positive multiple of SLICE");
    end

    state_t            state, state_next;
    logic [IDXW-1:0]   idx, idx_next;
    logic              carry_r, carry_next;
    logic [WIDTH-1:0]  a_r, a_next;
    logic [WIDTH-1:0]  b_r, b_next;
    logic [WIDTH-1:0]  work_sum, work_next;
    logic [WIDTH-1:0]  merged;
    logic [WIDTH-1:0]  sum_next;
    logic              cout_next, busy_next, done_next;

    int unsigned       lo;
    logic [SLICE-1:0]  slice_a, slice_b, slice_sum;
    logic              slice_cout;

    // Operand mux for the shared slice.
    always_comb begin
        lo      = 32'(idx) * SLICE;
        slice_a = a_r[lo +: SLICE];
        slice_b = b_r[lo +: SLICE];
    end

    rca_slice #(.SLICE(SLICE)) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_r),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Next-state and datapath update.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        carry_next = carry_r;
        a_next     = a_r;
        b_next     = b_r;
        work_next  = work_sum;
        sum_next   = sum;
        cout_next  = cout;
        merged     = work_sum;
        merged[lo +: SLICE] = slice_sum;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_next     = a;
                    b_next     = b;
                    carry_next = cin;
                    idx_next   = '0;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                work_next  = merged;
                carry_next = slice_cout;
                // Final slice goes straight into the result so sum never shows partials.
                if (idx == LAST_IDX) begin
                    sum_next   = merged;
                    cout_next  = slice_cout;
                    state_next = DONE;
                end else begin
                    idx_next = idx + IDXW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            carry_r  <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            work_sum <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            carry_r  <= carry_next;
            a_r      <= a_next;
            b_r      <= b_next;
            work_sum <= work_next;
            sum      <= sum_next;
            cout     <= cout_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

endmodule

// File: tb/tb_rca_seq_adder.sv
// Self-checking bench for rca_seq_adder: directed protocol cases plus randomized
// operands against an arithmetic reference.
module tb_rca_seq_adder;

    localparam int unsigned WIDTH  = 12;
    localparam int unsigned SLICE  = 3;
    localparam int unsigned NSLICE = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             busy, done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks = 0;
    int n_fail   = 0;
    int n_accept = 0;
    int n_done   = 0;
    logic [WIDTH:0] model_res;

    rca_seq_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle with start low.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic ci, input bit hold);
        logic [WIDTH:0] exp;
        exp   = (WIDTH+1)'(av) + (WIDTH+1)'(bv) + (WIDTH+1)'(ci);
        a     = av;
        b     = bv;
        cin   = ci;
        start = 1'b1;
        @(posedge clk);
        n_accept++;
        for (int k = 0; k < int'(NSLICE); k++) begin
            @(negedge clk);
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            check("run_hold_result", 32'({cout, sum}), 32'(model_res));
            if (!hold) start = 1'b0;
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom);
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("result", 32'({cout, sum}), 32'(exp));
        model_res = exp;
        start     = 1'b0;
    endtask

    task automatic idle_check(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check("idle_done", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        model_res = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'h000);
        check("reset_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        idle_check(3);

        run_op(12'h123, 12'h456, 1'b0, 1'b0);
        check("basic_sum", 32'(sum), 32'h579);
        check("basic_cout", 32'(cout), 32'd0);
        idle_check(1);

        run_op(12'hFFF, 12'h001, 1'b0, 1'b0);
        check("ripple_sum", 32'(sum), 32'h000);
        check("ripple_cout", 32'(cout), 32'd1);
        run_op(12'hFFF, 12'hFFF, 1'b1, 1'b0);
        check("max_sum", 32'(sum), 32'hFFF);
        check("max_cout", 32'(cout), 32'd1);
        idle_check(1);

        // start held through RUN with scrambled operands, then back-to-back accept.
        run_op(12'h0AA, 12'h055, 1'b1, 1'b1);
        check("hold_sum", 32'(sum), 32'h100);
        run_op(12'h001, 12'h002, 1'b0, 1'b0);
        check("b2b_sum", 32'(sum), 32'h003);
        check("b2b_cout", 32'(cout), 32'd0);
        idle_check(2);

        // Abort mid-operation with rst on E2.
        a     = 12'h800;
        b     = 12'h800;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_res = '0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'h000);
        check("abort_cout", 32'(cout), 32'd0);
        idle_check(NSLICE + 2);
        check("abort_no_done", 32'(n_done), 32'(n_accept));

        run_op(12'h800, 12'h800, 1'b0, 1'b0);
        check("post_abort_sum", 32'(sum), 32'h000);
        check("post_abort_cout", 32'(cout), 32'd1);

        for (int i = 0; i < 1000; i++) begin
            int gap;
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
            gap = $urandom_range(0, 3);
            idle_check(gap);
        end
        idle_check(2);
        check("done_count", 32'(n_done), 32'(n_accept));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
